// File: rtl/cpu_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// cpu_pkg : shared types and defaults for the load-multiple sequencer
// Rev 1.0
// ------------------------------------------------------------------
package cpu_pkg;

  localparam int REGS_DEFAULT = 16;
  localparam int AW_DEFAULT   = 16;
  localparam int DW_DEFAULT   = 16;
  localparam int IDX_W        = $clog2(REGS_DEFAULT);

  typedef enum logic [1:0] {
    LM_IDLE  = 2'd0,
    LM_ISSUE = 2'd1,
    LM_WRITE = 2'd2,
    LM_DONE  = 2'd3
  } lm_state_t;

endpackage
`default_nettype wire

// File: rtl/lowest_set_bit.sv
`default_nettype none
// ------------------------------------------------------------------
// lowest_set_bit : priority encoder giving the lowest set bit index
// Rev 1.0
// ------------------------------------------------------------------
module lowest_set_bit
  import cpu_pkg::*;
#(
  parameter int N  = REGS_DEFAULT,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          zero
);

  // Scanning downward leaves the lowest set index as the final winner.
  always_comb begin
    idx  = '0;
    zero = (vec == '0);
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = IW'(i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/lm_sequencer.sv
`default_nettype none
// ------------------------------------------------------------------
// lm_sequencer : load-multiple responder, one memory read per mask bit
// Rev 1.0
// ------------------------------------------------------------------
module lm_sequencer
  import cpu_pkg::*;
#(
  parameter  int REGS = REGS_DEFAULT,
  parameter  int AW   = AW_DEFAULT,
  parameter  int DW   = DW_DEFAULT,
  localparam int IW   = $clog2(REGS)
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            LM,
  input  logic [REGS-1:0] Mask,
  input  logic [AW-1:0]   Base,
  input  logic [DW-1:0]   MemData,
  output logic [AW-1:0]   MemAddr,
  output logic            MemRE,
  output logic [IW-1:0]   RegIdx,
  output logic [DW-1:0]   RegData,
  output logic            RegWE,
  output logic [AW-1:0]   NextSP,
  output logic            LMC,
  output logic            Busy
);

  localparam int CW = IW + 1;

  lm_state_t       state_q, state_d;
  logic [REGS-1:0] rem_q, rem_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [AW-1:0]   base_q, base_d;
  logic [AW-1:0]   next_sp_q, next_sp_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;

  logic [REGS-1:0] lsb_vec;
  logic [REGS-1:0] rem_cleared;
  logic [IW-1:0]   lsb_idx;
  logic            lsb_zero;

  // In IDLE the encoder only answers "is the incoming mask empty?".
  assign lsb_vec     = (state_q == LM_IDLE) ? Mask : rem_q;
  assign rem_cleared = rem_q & ~({{(REGS-1){1'b0}}, 1'b1} << idx_q);

  lowest_set_bit #(.N(REGS), .IW(IW)) u_lsb (
    .vec  (lsb_vec),
    .idx  (lsb_idx),
    .zero (lsb_zero)
  );

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    addr_d    = addr_q;
    base_d    = base_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    next_sp_d = next_sp_q;
    MemRE     = 1'b0;
    MemAddr   = '0;
    RegWE     = 1'b0;
    RegIdx    = '0;
    RegData   = '0;
    LMC       = 1'b0;
    NextSP    = '0;
    Busy      = 1'b0;
    case (state_q)
      LM_IDLE: begin
        if (LM) begin
          rem_d     = Mask;
          addr_d    = Base;
          base_d    = Base;
          cnt_d     = '0;
          next_sp_d = Base;
          state_d   = lsb_zero ? LM_DONE : LM_ISSUE;
        end
      end
      LM_ISSUE: begin
        Busy    = 1'b1;
        MemRE   = 1'b1;
        MemAddr = addr_q;
        idx_d   = lsb_idx;
        state_d = LM_WRITE;
      end
      LM_WRITE: begin
        Busy      = 1'b1;
        RegWE     = 1'b1;
        RegIdx    = idx_q;
        RegData   = MemData;
        rem_d     = rem_cleared;
        addr_d    = addr_q + AW'(1);
        cnt_d     = cnt_q + CW'(1);
        next_sp_d = base_q + AW'(cnt_d);
        state_d   = (rem_cleared == '0) ? LM_DONE : LM_ISSUE;
      end
      LM_DONE: begin
        LMC    = 1'b1;
        NextSP = next_sp_q;
        if (!LM) state_d = LM_IDLE;
      end
      default: state_d = LM_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= LM_IDLE;
      rem_q     <= '0;
      addr_q    <= '0;
      base_q    <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      next_sp_q <= '0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      addr_q    <= addr_d;
      base_q    <= base_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      next_sp_q <= next_sp_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lm_sequencer.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_lm_sequencer : table, hand-sequence and random checks of lm_sequencer
// Rev 1.0
// ------------------------------------------------------------------
module tb_lm_sequencer;
  import cpu_pkg::*;

  localparam int REGS = 16;
  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int IW   = 4;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          LM = 1'b0;
  logic [15:0]   Mask = '0;
  logic [15:0]   Base = '0;
  logic [15:0]   MemData = '0;
  logic [15:0]   MemAddr;
  logic          MemRE;
  logic [IW-1:0] RegIdx;
  logic [15:0]   RegData;
  logic          RegWE;
  logic [15:0]   NextSP;
  logic          LMC;
  logic          Busy;

  lm_sequencer #(.REGS(REGS), .AW(AW), .DW(DW)) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .LM      (LM),
    .Mask    (Mask),
    .Base    (Base),
    .MemData (MemData),
    .MemAddr (MemAddr),
    .MemRE   (MemRE),
    .RegIdx  (RegIdx),
    .RegData (RegData),
    .RegWE   (RegWE),
    .NextSP  (NextSP),
    .LMC     (LMC),
    .Busy    (Busy)
  );

  always #5 CLK = ~CLK;

  int          n_tests = 0;
  int          n_fail = 0;
  int          memre_cnt = 0;
  logic [15:0] mem_key = 16'hA5A5;
  logic [19:0] wr_q[$];

  // Memory: data valid the cycle after a read, junk otherwise.
  always @(posedge CLK) MemData <= MemRE ? (MemAddr ^ mem_key) : 16'($urandom);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(negedge CLK);
    check("memre_regwe_exclusive", {63'd0, MemRE & RegWE}, 64'd0);
    check("regdata_gated", RegWE ? 64'd0 : {48'd0, RegData}, 64'd0);
    if (MemRE) memre_cnt++;
    if (RegWE) wr_q.push_back({RegIdx, RegData});
  end

  function automatic int popc(input logic [15:0] m);
    int n = 0;
    for (int i = 0; i < 16; i++) if (m[i]) n++;
    return n;
  endfunction

  // Starts at a negedge with the DUT idle; ends at a negedge with the DUT idle.
  task automatic run_req(input string tag, input logic [15:0] m, input logic [15:0] b,
                         input int hold, input logic [15:0] exp_sp, input int exp_lat);
    logic [19:0] exp_q[$];
    logic [15:0] a;
    int k = 0;
    int lat = 0;
    int re0;
    for (int i = 0; i < REGS; i++) begin
      if (m[i]) begin
        a = b + 16'(k);
        exp_q.push_back({4'(i), a ^ mem_key});
        k++;
      end
    end
    Mask = m; Base = b; LM = 1'b1;
    wr_q.delete();
    re0 = memre_cnt;
    @(posedge CLK);
    #1 Mask = 16'($urandom); Base = 16'($urandom);
    for (int c = 1; c <= 64; c++) begin
      @(negedge CLK);
      if (LMC) begin lat = c; break; end
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_nextsp"}, {48'd0, NextSP}, {48'd0, exp_sp});
    check({tag, "_busy_done"}, {63'd0, Busy}, 64'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge CLK);
      check({tag, "_lmc_hold"}, {63'd0, LMC}, 64'd1);
    end
    LM = 1'b0;
    @(negedge CLK);
    check({tag, "_lmc_drop"}, {63'd0, LMC}, 64'd0);
    check({tag, "_memre_count"}, 64'(memre_cnt - re0), 64'(k));
    check({tag, "_write_count"}, 64'(wr_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
      check({tag, "_write"}, {44'd0, wr_q[i]}, {44'd0, exp_q[i]});
  endtask

  typedef struct {
    logic [15:0] mask;
    logic [15:0] base;
    int          hold;
    logic [15:0] sp;
    int          lat;
    int          nwr;
    logic [19:0] first;
    logic [19:0] last;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int nw;
    int re0;
    int lat;
    logic [15:0] m;
    logic [15:0] b;
    int n;

    tbl[0] = '{16'h0005, 16'h0100, 0, 16'h0102,  5,  2, 20'h0A4A5, 20'h2A4A4};
    tbl[1] = '{16'h0000, 16'h0200, 0, 16'h0200,  1,  0, 20'h00000, 20'h00000};
    tbl[2] = '{16'hFFFF, 16'hFFF8, 4, 16'h0008, 33, 16, 20'h05A5D, 20'hFA5A2};
    tbl[3] = '{16'h8000, 16'h1234, 0, 16'h1235,  3,  1, 20'hFB791, 20'hFB791};

    repeat (2) @(negedge CLK);
    check("reset_outputs", {8'd0, MemAddr, MemRE, RegIdx, RegData, RegWE, NextSP, LMC, Busy}, 64'd0);
    RST_N = 1'b1;
    @(negedge CLK);
    check("idle_outputs", {8'd0, MemAddr, MemRE, RegIdx, RegData, RegWE, NextSP, LMC, Busy}, 64'd0);

    for (int t = 0; t < 4; t++) begin
      run_req("table", tbl[t].mask, tbl[t].base, tbl[t].hold, tbl[t].sp, tbl[t].lat);
      if (tbl[t].nwr > 0) begin
        check("table_first", wr_q.size() > 0 ? {44'd0, wr_q[0]} : '1, {44'd0, tbl[t].first});
        check("table_last", wr_q.size() > 0 ? {44'd0, wr_q[$]} : '1, {44'd0, tbl[t].last});
      end
    end

    // Reset pulled during the second WRITE of a four-register load.
    Mask = 16'h00F0; Base = 16'h3000; LM = 1'b1;
    wr_q.delete();
    nw = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (RegWE) nw++;
      if (nw == 2) break;
    end
    check("rst_reach_second_write", 64'(nw), 64'd2);
    #2 RST_N = 1'b0;
    #1;
    check("rst_outputs_zero", {8'd0, MemAddr, MemRE, RegIdx, RegData, RegWE, NextSP, LMC, Busy}, 64'd0);
    LM = 1'b0;
    re0 = memre_cnt;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    check("rst_write_count", 64'(wr_q.size()), 64'd2);
    check("rst_second_write", wr_q.size() > 1 ? {44'd0, wr_q[1]} : '1, {44'd0, 20'h595A4});
    check("rst_no_memre", 64'(memre_cnt - re0), 64'd0);
    check("rst_idle", {62'd0, LMC, Busy}, 64'd0);
    run_req("post_rst", 16'h0003, 16'h0040, 0, 16'h0042, 5);

    // LM dropped during ISSUE must not cut the sequence short.
    Mask = 16'h0109; Base = 16'h7FFE; LM = 1'b1;
    wr_q.delete();
    @(negedge CLK);
    check("glitch_issue", {63'd0, MemRE}, 64'd1);
    LM = 1'b0;
    lat = 0;
    for (int c = 2; c <= 40; c++) begin
      @(negedge CLK);
      if (LMC) begin lat = c; break; end
    end
    check("glitch_latency", 64'(lat), 64'd7);
    check("glitch_nextsp", {48'd0, NextSP}, 64'h8001);
    @(negedge CLK);
    check("glitch_lmc_pulse", {62'd0, LMC, Busy}, 64'd0);
    @(negedge CLK);
    check("glitch_stay_idle", {62'd0, LMC, Busy}, 64'd0);
    check("glitch_write_count", 64'(wr_q.size()), 64'd3);
    check("glitch_last", wr_q.size() > 0 ? {44'd0, wr_q[$]} : '1, {44'd0, 20'h825A5});

    for (int r = 0; r < 40; r++) begin
      mem_key = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       m = 16'h0000;
        1:       m = 16'hFFFF;
        default: m = 16'($urandom);
      endcase
      b = 16'($urandom);
      n = popc(m);
      run_req("rand", m, b, int'($urandom_range(0, 3)), b + 16'(n), 2 * n + 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/lm_sequencer.md
# lm_sequencer

Multi-cycle load-multiple responder for the control unit. The control unit raises `LM` for a load-multiple instruction. This block then walks the instruction's register mask, issues one memory read per set bit from consecutive word addresses starting at `Base`, and writes each returned word into the register file. It answers with `LMC` through a four-phase handshake and presents the updated stack pointer on `NextSP`. It sits between the control unit, data memory port and register file write port.

## Interface
- `REGS`, 16: number of architectural registers, which is also the mask width.
- `AW`, 16: memory address width.
- `DW`, 16: data word width.
- `CLK` in 1: single clock, rising-edge.
- `RST_N` in 1: reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `LM` in 1: load-multiple request from the control unit, held high until `LMC` is seen.
- `Mask` in REGS: register list. Bit i set means load Ri. Sampled only when the request is accepted.
- `Base` in AW: start address (current SP). Sampled only when the request is accepted.
- `MemData` in DW: memory read data, valid one cycle after `MemRE`.
- `MemAddr` out AW: read address.
- `MemRE` out 1: memory read enable.
- `RegIdx` out log2(REGS): register file write index.
- `RegData` out DW: register file write data.
- `RegWE` out 1: register file write enable.
- `NextSP` out AW: `Base` + number of set mask bits, modulo 2^AW. Valid while `LMC`=1.
- `LMC` out 1: load-multiple complete.
- `Busy` out 1: high in ISSUE or WRITE.

## Operation
- States are IDLE, ISSUE, WRITE and DONE. Reset state is IDLE.
- IDLE:
  - On an edge with `LM`=1, latch `Mask` into `rem` and `Base` into `addr`, and clear `cnt`.
  - Go to ISSUE if `Mask`≠0, otherwise go to DONE.
- ISSUE:
  - `MemRE`=1 and `MemAddr`=`addr`.
  - Latch `idx` = lowest set bit of `rem`.
  - Go to WRITE.
- WRITE:
  - `RegWE`=1, `RegIdx`=`idx`, `RegData`=`MemData` (combinational pass-through).
  - At the edge: clear bit `idx` in `rem`, `addr`+=1 (wraps at 2^AW), `cnt`+=1.
  - Go to DONE if the cleared `rem` is 0, otherwise go to ISSUE.
- DONE:
  - `LMC`=1 and `NextSP`=`Base`+`cnt` (registered, modulo 2^AW).
  - Stay in DONE while `LM`=1. Go to IDLE on the first edge with `LM`=0.
- `LM` dropping during ISSUE or WRITE is ignored; the sequence completes.
- `Mask` and `Base` changes after acceptance are ignored.
- `cnt` is log2(REGS)+1 bits wide, so a full mask gives a count of 16.
- Registers are always loaded in ascending index order.

## Timing
- Reset values:
  - `MemAddr`, `RegIdx`, `RegData` (gated), `NextSP` = 0.
  - `MemRE`, `RegWE`, `LMC`, `Busy` = 0.
- Reset mid-sequence: return to IDLE immediately. No `RegWE` or `MemRE` after `RST_N` falls. Any pending write is dropped.
- Each register costs 2 cycles (ISSUE, then WRITE).
- Latency from the accepting edge to `LMC`=1 is 2·N+1 cycles for N set bits; N=0 gives 1 cycle.
- `MemRE` and `RegWE` are never both high in the same cycle.
- `RegData` is 0 whenever `RegWE`=0.
- Memory read latency is exactly 1 cycle and is not stallable.
- A new request is accepted only after `LM` has been low for at least one edge in DONE→IDLE. `LM` held high therefore never causes a restart.

## Structure
- Shared package `cpu_pkg`:
  - `lm_state_t` enum.
  - `REGS`, `AW` and `DW` defaults.
  - Register-index width constant.
- One sub-module, `lowest_set_bit`: combinational REGS-bit priority encoder that outputs the index and a zero flag. It is used in ISSUE and for the empty-mask check in IDLE.
- Otherwise flat: one state register, plus the `rem`, `addr`, `cnt`, `idx` and `NextSP` registers.

## Test plan
- Single request: `Mask`=0x0005, `Base`=0x0100, memory returns addr^0xA5A5.
  - Expect R0←0xA4A5 then R2←0xA4A4.
  - Expect `LMC` high 5 cycles after acceptance, with `NextSP`=0x0102.
- Empty mask: `Mask`=0x0000, `Base`=0x0200.
  - Expect no `MemRE`/`RegWE`.
  - Expect `LMC`=1 one cycle later, with `NextSP`=0x0200.
- Full mask with wrap: `Mask`=0xFFFF, `Base`=0xFFF8.
  - Expect R0..R15 loaded from addresses 0xFFF8..0xFFFF, then 0x0000..0x0007.
  - Expect `LMC` at cycle 33, with `NextSP`=0x0008.
- Handshake hold: keep `LM` high 4 cycles after `LMC`.
  - Expect `LMC` to stay 1 with no restart.
  - Drop `LM`: expect `LMC`=0 next edge.
  - Reassert `LM` with `Mask`=0x8000: expect a single R15 load.
- Reset mid-op: `Mask`=0x00F0, pulse `RST_N` low during the second WRITE.
  - Expect all outputs 0 immediately and no further `RegWE`.
  - After release, expect IDLE and a fresh request accepted normally.
- `LM` glitch: drop `LM` during ISSUE of a 3-bit mask.
  - Expect all 3 loads to complete.
  - Expect `LMC` to pulse for one cycle, then IDLE.
